exp_unit_arbiter: RTL and testbench



---
 rtl/exp_unit_arbiter.sv | 172 +++++++++++++++++
 tb/tb_exp_unit_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/exp_unit_arbiter.sv
// exp_unit_arbiter: round-robin scheduler sharing one CORDIC exponential unit among N requesters.
//
// Each operation runs IDLE -> CLR -> START -> WAIT -> FIN -> IDLE. The winner's argument is
// latched at grant time. The unit is cleared for one cycle, then started for one cycle. The
// arbiter then waits for ACK_EX. The captured result and flags go back to the winner with a
// one-cycle DONE pulse.
//
// Optional feature: define EXP_ARB_WATCHDOG_EN to enable a WAIT-state watchdog. After TO_CYC
// WAIT cycles without ACK_EX it finishes with TMO=1 and zeroed result and flags. When the
// macro is undefined, TMO is tied low and WAIT holds indefinitely.
//
// Ports:
//   CLK, RST      clock, asynchronous active-low reset
//   REQ[N]        per-requester request level
//   T_IN[N*P]     arguments; requester i occupies bits [i*P +: P]
//   GNT[N]        one-hot grant, held from latch until done
//   DONE[N]       one-hot, one-cycle completion pulse
//   RES_OUT[P]    result, valid with DONE and held afterwards
//   FLG_OUT[8]    {O_FX,O_FY,O_FZ,O_Fmult,U_FX,U_FY,U_FZ,U_Fmult}, held like RES_OUT
//   TMO           timeout indicator, qualified by DONE
//   BUSY          high in every state except IDLE
//   T_EX[P]       argument to the unit
//   RST_EX        active-high reset to the unit
//   Begin_FSM_EX  start pulse to the unit
//   ACK_EX        unit-complete strobe
//   FLG_EX[8]     unit flags
//   RES_EX[P]     unit result
module exp_unit_arbiter #(
    parameter int unsigned P      = 32,
    parameter int unsigned N      = 4,
    parameter int unsigned TO_CYC = 255
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [N-1:0]   REQ,
    input  logic [N*P-1:0] T_IN,
    output logic [N-1:0]   GNT,
    output logic [N-1:0]   DONE,
    output logic [P-1:0]   RES_OUT,
    output logic [7:0]     FLG_OUT,
    output logic           TMO,
    output logic           BUSY,
    output logic [P-1:0]   T_EX,
    output logic           RST_EX,
    output logic           Begin_FSM_EX,
    input  logic           ACK_EX,
    input  logic [7:0]     FLG_EX,
    input  logic [P-1:0]   RES_EX
);

    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {StIdle, StClr, StStart, StWait, StFin} state_e;

    state_e         state_q;
    logic [W-1:0]   ptr_q;
    logic [W-1:0]   win_q;
    logic [W-1:0]   pick;
    logic [N-1:0]   pick_oh;
    logic [P-1:0]   pick_arg;

    // (base + off) mod N, with off < N so the sum never exceeds 2N-2.
    function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] base, input int unsigned off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return W'(s);
    endfunction

    // Scan offsets from high to low so that the smallest offset from the pointer wins.
    always_comb begin
        pick = ptr_q;
        for (int i = N - 1; i >= 0; i--) begin
            if (REQ[wrap_idx(ptr_q, i)]) pick = wrap_idx(ptr_q, i);
        end
    end

    always_comb begin
        pick_oh  = '0;
        pick_arg = '0;
        for (int i = 0; i < N; i++) begin
            if (pick == W'(i)) begin
                pick_oh[i] = 1'b1;
                pick_arg   = T_IN[i*P +: P];
            end
        end
    end

`ifdef EXP_ARB_WATCHDOG_EN
    logic [15:0] wd_q;
`else
    assign TMO = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            win_q        <= '0;
            GNT          <= '0;
            DONE         <= '0;
            RES_OUT      <= '0;
            FLG_OUT      <= '0;
            BUSY         <= 1'b0;
            T_EX         <= '0;
            RST_EX       <= 1'b1;
            Begin_FSM_EX <= 1'b0;
`ifdef EXP_ARB_WATCHDOG_EN
            TMO          <= 1'b0;
            wd_q         <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    RST_EX <= 1'b0;
                    if (|REQ) begin
                        T_EX    <= pick_arg;
                        GNT     <= pick_oh;
                        win_q   <= pick;
                        RST_EX  <= 1'b1;  // high during CLR
                        BUSY    <= 1'b1;
                        state_q <= StClr;
                    end
                end
                StClr: begin
                    RST_EX       <= 1'b0;
                    Begin_FSM_EX <= 1'b1;  // high during START
                    state_q      <= StStart;
                end
                StStart: begin
                    Begin_FSM_EX <= 1'b0;
`ifdef EXP_ARB_WATCHDOG_EN
                    wd_q         <= '0;
`endif
                    state_q      <= StWait;
                end
                StWait: begin
                    // ACK takes priority over a watchdog expiry in the same cycle.
                    if (ACK_EX) begin
                        RES_OUT <= RES_EX;
                        FLG_OUT <= FLG_EX;
                        DONE    <= GNT;
`ifdef EXP_ARB_WATCHDOG_EN
                        TMO     <= 1'b0;
`endif
                        state_q <= StFin;
                    end
`ifdef EXP_ARB_WATCHDOG_EN
                    else if (wd_q == 16'(TO_CYC - 1)) begin
                        RES_OUT <= '0;
                        FLG_OUT <= '0;
                        TMO     <= 1'b1;
                        DONE    <= GNT;
                        state_q <= StFin;
                    end else begin
                        wd_q <= wd_q + 16'd1;
                    end
`endif
                end
                StFin: begin
                    DONE    <= '0;
                    GNT     <= '0;
                    BUSY    <= 1'b0;
                    ptr_q   <= (win_q == W'(N - 1)) ? '0 : win_q + 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_unit_arbiter.sv
// tb_exp_unit_arbiter: directed self-checking bench for exp_unit_arbiter.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_exp_unit_arbiter;

    localparam int unsigned P = 32;
    localparam int unsigned N = 4;
`ifdef EXP_ARB_WATCHDOG_EN
    localparam int unsigned TO = 20;
`else
    localparam int unsigned TO = 255;
`endif

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ;
    logic [N*P-1:0] T_IN;
    logic [N-1:0]   GNT, DONE;
    logic [P-1:0]   RES_OUT, T_EX, RES_EX;
    logic [7:0]     FLG_OUT, FLG_EX;
    logic           TMO, BUSY, RST_EX, Begin_FSM_EX, ACK_EX;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    exp_unit_arbiter #(.P(P), .N(N), .TO_CYC(TO)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .T_IN(T_IN), .GNT(GNT), .DONE(DONE),
        .RES_OUT(RES_OUT), .FLG_OUT(FLG_OUT), .TMO(TMO), .BUSY(BUSY), .T_EX(T_EX),
        .RST_EX(RST_EX), .Begin_FSM_EX(Begin_FSM_EX), .ACK_EX(ACK_EX), .FLG_EX(FLG_EX),
        .RES_EX(RES_EX)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation. mode 1 drops REQ after grant; mode 2 scrambles T_IN after grant.
    task automatic run_op(input string tag, input logic [N-1:0] exp_gnt,
                          input logic [P-1:0] exp_t, input logic [P-1:0] res,
                          input logic [7:0] flg, input int dly, input int mode);
        int k;
        logic [N*P-1:0] saved;
        k = 0;
        do begin @(negedge CLK); k++; end while (GNT == '0 && k < 10);
        check_val({tag, ".gnt"}, GNT, exp_gnt);
        check_val({tag, ".t_ex"}, T_EX, exp_t);
        check_val({tag, ".clr"}, {RST_EX, Begin_FSM_EX, BUSY}, 3'b101);
        if (mode == 1) REQ = '0;
        saved = T_IN;
        if (mode == 2) T_IN = ~T_IN;
        @(negedge CLK);
        check_val({tag, ".start"}, {RST_EX, Begin_FSM_EX}, 2'b01);
        repeat (dly) @(negedge CLK);
        ACK_EX = 1'b1;
        RES_EX = res;
        FLG_EX = flg;
        k = 0;
        do begin @(negedge CLK); k++; end while (DONE == '0 && k < 5);
        check_val({tag, ".ack_lat"}, k, (dly == 0) ? 2 : 1);
        ACK_EX = 1'b0;
        RES_EX = 32'hDEAD_BEEF;
        FLG_EX = 8'h5A;
        check_val({tag, ".done"}, DONE, exp_gnt);
        check_val({tag, ".res"}, RES_OUT, res);
        check_val({tag, ".flg"}, FLG_OUT, flg);
        check_val({tag, ".tmo"}, TMO, 1'b0);
        check_val({tag, ".t_hold"}, T_EX, exp_t);
        T_IN = saved;
        @(negedge CLK);
        check_val({tag, ".after"}, {DONE, GNT, BUSY}, '0);
        check_val({tag, ".res_hold"}, {RES_OUT, FLG_OUT}, {res, flg});
    endtask

    initial begin
        #2ms;
        $display("FAIL sim_time_limit: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int k;
        logic seen;
        RST = 1'b0; REQ = '0; ACK_EX = 1'b0; RES_EX = '0; FLG_EX = '0;
        for (int i = 0; i < N; i++) T_IN[i*P +: P] = 32'hA000_0000 + i;

        // Reset values
        repeat (2) @(negedge CLK);
        check_val("rst.outs", {GNT, DONE, BUSY, Begin_FSM_EX, TMO}, '0);
        check_val("rst.data", {T_EX, RES_OUT, FLG_OUT}, '0);
        check_val("rst.rst_ex", RST_EX, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        check_val("idle.rst_ex", {RST_EX, BUSY}, 2'b00);

        // Fairness: all requesting, grants rotate 0..3 twice
        REQ = '1;
        for (int i = 0; i < 8; i++)
            run_op($sformatf("fair%0d", i), 4'b0001 << (i % 4), 32'hA000_0000 + (i % 4),
                   32'h1000 + i, 8'h00, 3, 0);
        REQ = '0;

        // Single request, ACK 12 cycles after start, argument change after latch
        T_IN[P +: P] = 32'h3F80_0000;
        REQ = 4'b0010;
        run_op("single", 4'b0010, 32'h3F80_0000, 32'h402D_F854, 8'h00, 12, 2);
        REQ = '0;
        repeat (3) @(negedge CLK);
        check_val("single.busy_low", BUSY, 1'b0);
        T_IN[P +: P] = 32'hA000_0001;

        // Withdrawal after grant
        REQ = 4'b0100;
        run_op("withdraw", 4'b0100, 32'hA000_0002, 32'h1234_5678, 8'h00, 2, 1);
        seen = 1'b0;
        repeat (5) begin @(negedge CLK); seen |= |GNT; end
        check_val("withdraw.no_regrant", seen, 1'b0);

        // Flags, ACK already high when WAIT is entered
        REQ = 4'b1000;
        run_op("flags", 4'b1000, 32'hA000_0003, 32'hCAFE_F00D, 8'b1000_0001, 0, 0);
        REQ = '0;
        repeat (3) @(negedge CLK);
        check_val("flags.held", FLG_OUT, 8'b1000_0001);

        // Pointer wraps to 0, then 1 wins over still-pending 0
        REQ = 4'b0011;
        run_op("wrap0", 4'b0001, 32'hA000_0000, 32'h0000_0A0A, 8'h10, 1, 0);
        run_op("wrap1", 4'b0010, 32'hA000_0001, 32'h0000_0B0B, 8'h01, 1, 0);
        REQ = '0;

        // Reset in the middle of WAIT
        REQ = 4'b0001;
        k = 0;
        do begin @(negedge CLK); k++; end while (!Begin_FSM_EX && k < 10);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check_val("midrst.async", {GNT, BUSY, Begin_FSM_EX, RST_EX}, {4'b0000, 3'b001});
        REQ = '0;
        seen = 1'b0;
        repeat (2) begin @(negedge CLK); seen |= |DONE; end
        check_val("midrst.rst_ex_held", RST_EX, 1'b1);
        RST = 1'b1;
        ACK_EX = 1'b1;  // stray ACK while idle must be ignored
        repeat (4) begin @(negedge CLK); seen |= |DONE | |GNT; end
        ACK_EX = 1'b0;
        check_val("midrst.no_done", seen, 1'b0);
        check_val("midrst.idle", {BUSY, RST_EX}, 2'b00);

        // Pointer was reset to 0, so requester 1 wins here
        REQ = 4'b0110;
        run_op("post_rst", 4'b0010, 32'hA000_0001, 32'h7777_0001, 8'h00, 1, 0);
        REQ = '0;

`ifdef EXP_ARB_WATCHDOG_EN
        // Watchdog: no ACK
        REQ = 4'b0001;
        k = 0;
        do begin @(negedge CLK); k++; end while (GNT == '0 && k < 10);
        REQ = '0;
        k = 0;
        do begin @(negedge CLK); k++; end while (DONE == '0 && k < 60);
        check_val("wd.done", DONE, 4'b0001);
        check_val("wd.tmo", TMO, 1'b1);
        check_val("wd.res", {RES_OUT, FLG_OUT}, '0);
        @(negedge CLK);
        REQ = 4'b0010;
        k = 0;
        do begin @(negedge CLK); k++; end while (GNT == '0 && k < 10);
        check_val("wd.clr", RST_EX, 1'b1);
        REQ = '0;
        @(negedge CLK);
        ACK_EX = 1'b1;
        RES_EX = 32'h5555_0000;
        k = 0;
        do begin @(negedge CLK); k++; end while (DONE == '0 && k < 5);
        ACK_EX = 1'b0;
        check_val("wd.next_done", DONE, 4'b0010);
        check_val("wd.next_tmo", TMO, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
